// File: rtl/serial_parity_checker.sv
// serial_parity_checker: LSB-first start/data/parity/stop deframer with XOR parity check.
// Define PARITY_ERROR_COUNT_EN to add err_clear and a saturating err_count.
module serial_parity_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bit_valid,
    input  logic                  bit_in,
`ifdef PARITY_ERROR_COUNT_EN
    input  logic                  err_clear,
    output logic [7:0]            err_count,
`endif
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  frame_error,
    output logic                  busy
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic PAR_INIT = (ODD_PARITY != 0);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state, next_state;
    logic [CW-1:0] count;
    logic [DATA_WIDTH-1:0] shift;
    logic acc, mismatch, last_data;
    assign last_data = (count == CW'(DATA_WIDTH - 1));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = state;
        if (bit_valid)
            case (state)
                IDLE:    next_state = bit_in ? IDLE : DATA;
                DATA:    next_state = last_data ? PARITY : DATA;
                PARITY:  next_state = STOP;
                default: next_state = IDLE;
            endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= '0;
            acc          <= 1'b0;
            mismatch     <= 1'b0;
            shift        <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            busy         <= (next_state != IDLE);
            if (bit_valid)
                case (state)
                    IDLE: if (!bit_in) begin
                        count <= '0;
                        acc   <= PAR_INIT;
                    end
                    DATA: begin
                        // counter value is the bit position, so no barrel shift is needed
                        for (int i = 0; i < DATA_WIDTH; i++)
                            if (count == CW'(i)) shift[i] <= bit_in;
                        acc   <= acc ^ bit_in;
                        count <= count + 1'b1;
                    end
                    PARITY: mismatch <= acc ^ bit_in;
                    default: if (bit_in) begin
                        data_out     <= shift;
                        data_valid   <= 1'b1;
                        parity_error <= mismatch;
                    end else begin
                        frame_error  <= 1'b1;
                    end
                endcase
        end
    end
`ifdef PARITY_ERROR_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_count <= '0;
        else if (err_clear) err_count <= '0;
        else if ((parity_error | frame_error) && err_count != 8'hFF) err_count <= err_count + 1'b1;
    end
`endif
endmodule

// File: tb/tb_serial_parity_checker.sv
// tb_serial_parity_checker: table, directed and random checks of an even and an odd parity instance.
module tb_serial_parity_checker;
    localparam int W = 8;
    logic clk = 1'b0;
    logic reset, bit_valid, bit_in;
    logic [W-1:0] dout_e, dout_o;
    logic dv_e, pe_e, fe_e, busy_e, dv_o, pe_o, fe_o, busy_o;
`ifdef PARITY_ERROR_COUNT_EN
    logic err_clear = 1'b0;
    logic [7:0] cnt_e, cnt_o;
`endif
    int errors = 0, checks = 0;
    always #5 clk = ~clk;

    serial_parity_checker #(.DATA_WIDTH(W), .ODD_PARITY(0)) u_even (
        .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
`ifdef PARITY_ERROR_COUNT_EN
        .err_clear(err_clear), .err_count(cnt_e),
`endif
        .data_out(dout_e), .data_valid(dv_e), .parity_error(pe_e), .frame_error(fe_e), .busy(busy_e));

    serial_parity_checker #(.DATA_WIDTH(W), .ODD_PARITY(1)) u_odd (
        .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
`ifdef PARITY_ERROR_COUNT_EN
        .err_clear(err_clear), .err_count(cnt_o),
`endif
        .data_out(dout_o), .data_valid(dv_o), .parity_error(pe_o), .frame_error(fe_o), .busy(busy_o));

    // reference: collect bits after a start bit, evaluate the frame once it is complete
    int m_busy, m_q[$], m_data, m_dv, m_pe_e, m_pe_o, m_fe, m_cnt;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_all(string name);
        check({name, "_even"}, {dout_e, dv_e, pe_e, fe_e, busy_e},
              {m_data[W-1:0], m_dv[0], m_pe_e[0], m_fe[0], m_busy[0]});
        check({name, "_odd"}, {dout_o, dv_o, pe_o, fe_o, busy_o},
              {m_data[W-1:0], m_dv[0], m_pe_o[0], m_fe[0], m_busy[0]});
`ifdef PARITY_ERROR_COUNT_EN
        check({name, "_cnt"}, cnt_e, m_cnt);
`endif
    endtask

    task automatic model_edge(logic v, logic b);
        int ones;
`ifdef PARITY_ERROR_COUNT_EN
        if (err_clear) m_cnt = 0;
        else if ((m_pe_e != 0 || m_fe != 0) && m_cnt < 255) m_cnt++;
`endif
        m_dv = 0; m_pe_e = 0; m_pe_o = 0; m_fe = 0;
        if (!v) return;
        if (m_busy == 0) begin
            if (b == 1'b0) begin m_busy = 1; m_q.delete(); end
            return;
        end
        m_q.push_back(int'(b));
        if (m_q.size() == W + 2) begin
            ones = 0;
            for (int k = 0; k < W; k++) ones += m_q[k];
            if (m_q[W + 1] == 1) begin
                m_data = 0;
                for (int k = 0; k < W; k++) m_data += m_q[k] * (1 << k);
                m_dv = 1;
                m_pe_e = (ones % 2) != m_q[W];
                m_pe_o = ((ones + 1) % 2) != m_q[W];
            end else m_fe = 1;
            m_busy = 0;
        end
    endtask

    task automatic step(logic v, logic b);
        bit_valid = v; bit_in = b;
        @(posedge clk);
        model_edge(v, b);
        #1;
        check_all("step");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset_even", {dout_e, dv_e, pe_e, fe_e, busy_e}, 0);
        check("reset_odd", {dout_o, dv_o, pe_o, fe_o, busy_o}, 0);
        m_busy = 0; m_data = 0; m_dv = 0; m_pe_e = 0; m_pe_o = 0; m_fe = 0; m_cnt = 0;
        m_q.delete();
`ifdef PARITY_ERROR_COUNT_EN
        check("reset_cnt", cnt_e, 0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send_frame(logic [W-1:0] d, logic p, logic s, bit gapped);
        logic [W+1:0] bits;
        bits = {s, p, d};
        step(1'b1, 1'b0);
        for (int k = 0; k < W + 2; k++) begin
            if (gapped) step(1'b0, 1'($urandom_range(0, 1)));
            step(1'b1, bits[k]);
        end
    endtask

    typedef struct {
        logic [W-1:0] d;
        logic p, s;
        logic [W-1:0] exp_data;
        logic exp_dv, exp_pe, exp_fe;
    } vec_t;
    vec_t tbl[8];

    initial begin
        tbl[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{8'h5A, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{8'hFF, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
        bit_valid = 1'b0; bit_in = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].d, tbl[i].p, tbl[i].s, 1'b0);
            check($sformatf("table%0d", i), {dout_e, dv_e, pe_e, fe_e, busy_e},
                  {tbl[i].exp_data, tbl[i].exp_dv, tbl[i].exp_pe, tbl[i].exp_fe, 1'b0});
        end
        step(1'b1, 1'b1);
        check("pulse_one_cycle", {dv_e, pe_e, fe_e}, 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            check("idle_busy", busy_e, 0);
        end
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        check("gapped", {dout_e, dv_e, pe_e}, {8'h3C, 1'b1, 1'b0});
        step(1'b1, 1'b0);
        check("busy_rise", busy_e, 1);
        for (int k = 0; k < 4; k++) step(1'b1, 1'(k & 1));
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1);
            check("no_pulse_after_reset", {dv_e, fe_e, dv_o, fe_o}, 0);
        end
        send_frame(8'h01, 1'b0, 1'b1, 1'b0);
        check("odd_frame", {dout_o, dv_o, pe_o, fe_o}, {8'h01, 1'b1, 1'b0, 1'b0});
`ifdef PARITY_ERROR_COUNT_EN
        do_reset();
        for (int i = 0; i < 3; i++) send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("cnt3", cnt_e, 3);
        for (int i = 0; i < 260; i++) send_frame(8'h11, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("cnt_sat", cnt_e, 255);
        send_frame(8'h00, 1'b1, 1'b1, 1'b0);
        err_clear = 1'b1;
        step(1'b1, 1'b1);
        err_clear = 1'b0;
        check("cnt_clear", cnt_e, 0);
`endif
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
`ifdef PARITY_ERROR_COUNT_EN
            err_clear = ($urandom_range(0, 99) == 0);
`endif
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
